// File: rtl/mouse_cursor_tracker.sv
// rtl/mouse_cursor_tracker.sv - PS/2 mouse packet assembler and clamped cursor tracker
// Builds 3-byte movement packets and accumulates deltas into an on-screen cursor position.
module mouse_cursor_tracker #(
  parameter int nX             = 8,
  parameter int nY             = 7,
  parameter int COLS           = 160,
  parameter int ROWS           = 120,
  parameter int SPEED_SHIFT    = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_data_en,
  output logic [nX-1:0] mouse_x,
  output logic [nY-1:0] mouse_y,
  output logic [2:0]    buttons,
  output logic          left_click,
  output logic          packet_done
);

  localparam int W  = ((nX > nY) ? nX : nY) + 3;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]       CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [W-1:0] X_MAX   = W'(COLS - 1);
  localparam logic signed [W-1:0] Y_MAX   = W'(ROWS - 1);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // hdr = {y_ovf, x_ovf, y_sign, x_sign, middle, right, left}
  logic [6:0]     hdr_q, hdr_d;
  logic [7:0]     xbyte_q, xbyte_d;
  logic [7:0]     ybyte_q, ybyte_d;
  logic [nX-1:0]  mouse_x_q, mouse_x_d;
  logic [nY-1:0]  mouse_y_q, mouse_y_d;
  logic [2:0]     buttons_q, buttons_d;
  logic           left_click_q, left_click_d;
  logic           packet_done_q, packet_done_d;

  logic signed [8:0]   dx9, dy9, dx, dy;
  logic signed [W-1:0] nx, ny;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    xbyte_d = xbyte_q;
    ybyte_d = ybyte_q;
    case (state_q)
      WAIT_B0, UPDATE: begin
        cnt_d   = '0;
        state_d = WAIT_B0;
        if (ps2_data_en && ps2_data[3]) begin
          hdr_d   = {ps2_data[7:4], ps2_data[2:0]};
          state_d = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (ps2_data_en) begin
          xbyte_d = ps2_data;
          cnt_d   = '0;
          state_d = WAIT_B2;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_B2: begin
        if (ps2_data_en) begin
          ybyte_d = ps2_data;
          cnt_d   = '0;
          state_d = UPDATE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = WAIT_B0;
    endcase
  end

  // PS/2 reports +Y as upward motion, screen rows grow downward.
  always_comb begin
    dx9 = $signed({hdr_q[3], xbyte_q});
    dy9 = $signed({hdr_q[4], ybyte_q});
    dx  = hdr_q[5] ? 9'sd0 : (dx9 >>> SPEED_SHIFT);
    dy  = hdr_q[6] ? 9'sd0 : (dy9 >>> SPEED_SHIFT);
    nx  = $signed({{(W-nX){1'b0}}, mouse_x_q}) + W'(dx);
    ny  = $signed({{(W-nY){1'b0}}, mouse_y_q}) - W'(dy);

    mouse_x_d     = mouse_x_q;
    mouse_y_d     = mouse_y_q;
    buttons_d     = buttons_q;
    left_click_d  = 1'b0;
    packet_done_d = 1'b0;
    if (state_q == UPDATE) begin
      if (nx[W-1])         mouse_x_d = '0;
      else if (nx > X_MAX) mouse_x_d = X_MAX[nX-1:0];
      else                 mouse_x_d = nx[nX-1:0];
      if (ny[W-1])         mouse_y_d = '0;
      else if (ny > Y_MAX) mouse_y_d = Y_MAX[nY-1:0];
      else                 mouse_y_d = ny[nY-1:0];
      buttons_d     = hdr_q[2:0];
      left_click_d  = hdr_q[0] && !buttons_q[0];
      packet_done_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= WAIT_B0;
      cnt_q         <= '0;
      hdr_q         <= '0;
      xbyte_q       <= '0;
      ybyte_q       <= '0;
      mouse_x_q     <= nX'(COLS / 2);
      mouse_y_q     <= nY'(ROWS / 2);
      buttons_q     <= '0;
      left_click_q  <= 1'b0;
      packet_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      xbyte_q       <= xbyte_d;
      ybyte_q       <= ybyte_d;
      mouse_x_q     <= mouse_x_d;
      mouse_y_q     <= mouse_y_d;
      buttons_q     <= buttons_d;
      left_click_q  <= left_click_d;
      packet_done_q <= packet_done_d;
    end
  end

  assign mouse_x     = mouse_x_q;
  assign mouse_y     = mouse_y_q;
  assign buttons     = buttons_q;
  assign left_click  = left_click_q;
  assign packet_done = packet_done_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// tb/tb_mouse_cursor_tracker.sv - directed table-driven bench for mouse_cursor_tracker
module tb_mouse_cursor_tracker;

  logic       clock;
  logic       resetn;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic [7:0] mouse_x;
  logic [6:0] mouse_y;
  logic [2:0] buttons;
  logic       left_click;
  logic       packet_done;

  int checks = 0;
  int errors = 0;

  mouse_cursor_tracker #(
    .nX(8), .nY(7), .COLS(160), .ROWS(120), .SPEED_SHIFT(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_data    (ps2_data),
    .ps2_data_en (ps2_data_en),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .buttons     (buttons),
    .left_click  (left_click),
    .packet_done (packet_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         x;
    int         y;
    int         btn;
    int         lc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    ps2_data    = b;
    ps2_data_en = 1'b1;
    @(negedge clock);
    ps2_data_en = 1'b0;
    ps2_data    = 8'h00;
  endtask

  // Returns #1 after the edge that follows UPDATE (packet_done cycle).
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clock);
    ps2_data    = b0;
    ps2_data_en = 1'b1;
    @(negedge clock);
    ps2_data    = b1;
    @(negedge clock);
    ps2_data    = b2;
    @(negedge clock);
    ps2_data_en = 1'b0;
    ps2_data    = 8'h00;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_pos(input string nm, input int x, input int y);
    chk({nm, "_x"}, int'(mouse_x), x);
    chk({nm, "_y"}, int'(mouse_y), y);
    chk({nm, "_done"}, int'(packet_done), 1);
  endtask

  initial begin
    int pd_seen;

    vecs[0]  = '{8'h08, 8'h05, 8'h03,  85,  57, 0, 0};
    vecs[1]  = '{8'h18, 8'hF6, 8'h00,  75,  57, 0, 0};
    vecs[2]  = '{8'h28, 8'h00, 8'hEC,  75,  77, 0, 0};
    vecs[3]  = '{8'h08, 8'h7F, 8'h00, 159,  77, 0, 0};
    vecs[4]  = '{8'h08, 8'h7F, 8'h00, 159,  77, 0, 0};
    vecs[5]  = '{8'h48, 8'h7F, 8'h05, 159,  72, 0, 0};
    vecs[6]  = '{8'h08, 8'h00, 8'h7F, 159,   0, 0, 0};
    vecs[7]  = '{8'h28, 8'h00, 8'h80, 159, 119, 0, 0};
    vecs[8]  = '{8'h18, 8'h00, 8'h00,   0, 119, 0, 0};
    vecs[9]  = '{8'h09, 8'h00, 8'h00,   0, 119, 1, 1};
    vecs[10] = '{8'h09, 8'h00, 8'h00,   0, 119, 1, 0};
    vecs[11] = '{8'h08, 8'h00, 8'h00,   0, 119, 0, 0};
    vecs[12] = '{8'h09, 8'h00, 8'h00,   0, 119, 1, 1};
    vecs[13] = '{8'h0E, 8'h00, 8'h00,   0, 119, 6, 0};
    vecs[14] = '{8'h8F, 8'h01, 8'h05,   1, 119, 7, 1};
    vecs[15] = '{8'h08, 8'h50, 8'h01,  81, 118, 0, 0};

    resetn      = 1'b0;
    ps2_data    = 8'h00;
    ps2_data_en = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_x", int'(mouse_x), 80);
    chk("rst_y", int'(mouse_y), 60);
    chk("rst_btn", int'(buttons), 0);
    chk("rst_done", int'(packet_done), 0);
    chk("rst_click", int'(left_click), 0);

    for (int i = 0; i < 16; i++) begin
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      chk($sformatf("vec%0d_x", i), int'(mouse_x), vecs[i].x);
      chk($sformatf("vec%0d_y", i), int'(mouse_y), vecs[i].y);
      chk($sformatf("vec%0d_btn", i), int'(buttons), vecs[i].btn);
      chk($sformatf("vec%0d_done", i), int'(packet_done), 1);
      chk($sformatf("vec%0d_click", i), int'(left_click), vecs[i].lc);
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_done_off", i), int'(packet_done), 0);
      chk($sformatf("vec%0d_click_off", i), int'(left_click), 0);
    end

    send_byte(8'h00);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk_pos("resync", 82, 117);

    send_byte(8'h08);
    pd_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      if (packet_done) pd_seen++;
    end
    chk("timeout_b1_nodone", pd_seen, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk_pos("timeout_b1", 83, 116);

    send_byte(8'h08);
    send_byte(8'h01);
    pd_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      if (packet_done) pd_seen++;
    end
    chk("timeout_b2_nodone", pd_seen, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk_pos("timeout_b2", 84, 115);

    send_pkt(8'h09, 8'h00, 8'h00);
    chk("pre_rst_btn", int'(buttons), 1);
    send_byte(8'h08);
    send_byte(8'h05);
    resetn = 1'b0;
    #1;
    chk("midrst_x", int'(mouse_x), 80);
    chk("midrst_y", int'(mouse_y), 60);
    chk("midrst_btn", int'(buttons), 0);
    chk("midrst_done", int'(packet_done), 0);
    chk("midrst_click", int'(left_click), 0);
    @(negedge clock);
    resetn = 1'b1;
    send_pkt(8'h08, 8'h02, 8'h00);
    chk_pos("post_rst", 82, 60);

    @(negedge clock);
    ps2_data_en = 1'b1;
    ps2_data = 8'h08;
    @(negedge clock);
    ps2_data = 8'h01;
    @(negedge clock);
    ps2_data = 8'h00;
    @(negedge clock);
    ps2_data = 8'h08;
    @(posedge clock);
    #1;
    chk_pos("upd_strobe_first", 83, 60);
    @(negedge clock);
    ps2_data = 8'h03;
    @(posedge clock);
    #1;
    chk("upd_strobe_gap_done", int'(packet_done), 0);
    @(negedge clock);
    ps2_data = 8'h00;
    @(negedge clock);
    ps2_data_en = 1'b0;
    @(posedge clock);
    #1;
    chk_pos("upd_strobe_second", 86, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
